// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State encoding is kept to 2 bits so it stays readable in waveforms.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side (fetch + data) and memory-side signals of the arbiter.
// The arbiter uses the slave view; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_accept;
    logic              if_flush;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic              pipe_stall;
    logic              bus_err;

    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ready;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, if_accept, if_flush,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  ram_ready, ram_rdata,
        output if_valid, if_instr, mem_done, mem_rdata,
        output pipe_stall, bus_err,
        output ram_req, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, if_accept, if_flush,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output ram_ready, ram_rdata,
        input  if_valid, if_instr, mem_done, mem_rdata,
        input  pipe_stall, bus_err,
        input  ram_req, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Bare cycle counter for an outstanding memory access; the arbiter FSM
// decides what to do when it expires.
module mem_port_arbiter_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// MEM-priority, non-preemptive arbiter sharing one memory port between
// instruction fetch and data access, with a one-entry fetch buffer.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   port
);
    arb_state_t        state, state_nx;
    logic              grant_data, grant_fetch;
    logic              busy, finish, abort, expire, fill;
    logic              req_q, we_q, discard_q, valid_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, instr_q;

    assign busy   = (state != ST_IDLE);
    assign finish = busy & port.ram_ready;
    assign abort  = busy & expire & ~port.ram_ready;
    assign fill   = (state == ST_FETCH) & port.ram_ready & ~discard_q & ~port.if_flush;

    mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (grant_data | grant_fetch),
        .enable (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Data wins ties; a fetch is granted only when the buffer will have room.
    always_comb begin
        state_nx    = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        case (state)
            ST_IDLE: begin
                if (port.mem_rd | port.mem_wr) begin
                    grant_data = 1'b1;
                    state_nx   = ST_DATA;
                end else if (port.if_req & ~port.if_flush & (~valid_q | port.if_accept)) begin
                    grant_fetch = 1'b1;
                    state_nx    = ST_FETCH;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (finish | abort) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            req_q <= (state_nx != ST_IDLE);
            if (grant_data) begin
                we_q    <= port.mem_wr;
                addr_q  <= port.mem_addr;
                wdata_q <= port.mem_wdata;
            end else if (grant_fetch) begin
                we_q    <= 1'b0;
                addr_q  <= port.if_addr;
                wdata_q <= '0;
            end else if (state_nx == ST_IDLE) begin
                we_q <= 1'b0;
            end
        end
    end

    // A flush during a fetch marks the returning word stale until FETCH exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state != ST_FETCH || state_nx == ST_IDLE) discard_q <= 1'b0;
            else if (port.if_flush)                       discard_q <= 1'b1;

            if (port.if_flush) begin
                valid_q <= 1'b0;
            end else if (fill) begin
                valid_q <= 1'b1;
                instr_q <= port.ram_rdata;
            end else if (port.if_accept) begin
                valid_q <= 1'b0;
            end

            if (abort) err_q <= 1'b1;
        end
    end

    always_comb begin
        port.mem_done  = (state == ST_DATA) & (port.ram_ready | expire);
        port.mem_rdata = '0;
        if (state == ST_DATA && port.ram_ready && !we_q) port.mem_rdata = port.ram_rdata;
        port.pipe_stall = (port.mem_rd | port.mem_wr) & ~port.mem_done;
    end

    assign port.if_valid  = valid_q;
    assign port.if_instr  = instr_q;
    assign port.bus_err   = err_q;
    assign port.ram_req   = req_q;
    assign port.ram_we    = we_q;
    assign port.ram_addr  = addr_q;
    assign port.ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model
// returning addr ^ 0xC0DE0000 on every completion.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   lat = 1;
    int   cnt = 0;
    logic stray = 1'b0;
    int   reqs;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (bus)
    );

    // Memory model: ready on the lat-th cycle of a held request.
    always @(posedge clk) begin
        #1;
        if (bus.ram_req) cnt++;
        else             cnt = 0;
        bus.ram_ready = stray || (bus.ram_req && cnt == lat);
        bus.ram_rdata = bus.ram_ready ? (bus.ram_addr ^ 32'hC0DE_0000) : 32'h0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin
            nxt();
            n++;
        end while (bus.ram_req && n < bound);
        chk("idle_wait", bus.ram_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: still running, required $finish");
        $fatal(1);
    end

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.if_accept = 0; bus.if_flush = 0;
        bus.mem_rd = 0; bus.mem_wr = 0; bus.mem_addr = 0; bus.mem_wdata = 0;

        // Reset state
        nxt(); nxt();
        chk("rst_req", bus.ram_req, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_err", bus.bus_err, 0);
        chk("rst_stall", bus.pipe_stall, 0);

        // 1: plain fetch, latency 3
        rst_n = 1; bus.if_req = 1; bus.if_addr = 32'h100; lat = 3;
        nxt();
        chk("t1_addr", bus.ram_addr, 32'h100);
        chk("t1_we", bus.ram_we, 0);
        reqs = int'(bus.ram_req);
        for (int i = 0; i < 4; i++) begin
            nxt();
            reqs += int'(bus.ram_req);
        end
        chk("t1_req_cycles", reqs, 3);
        chk("t1_valid", bus.if_valid, 1);
        chk("t1_instr", bus.if_instr, 32'hC0DE_0100);
        chk("t1_err", bus.bus_err, 0);

        // 2: load arrives while a fetch is in flight
        bus.if_accept = 1; bus.if_addr = 32'h104; lat = 2;
        nxt();
        chk("t2_valid_consumed", bus.if_valid, 0);
        chk("t2_fetch_addr", bus.ram_addr, 32'h104);
        bus.if_accept = 0; bus.mem_rd = 1; bus.mem_addr = 32'h2000;
        nxt();
        chk("t2_fetch_kept", bus.ram_addr, 32'h104);
        chk("t2_stall_fetch", bus.pipe_stall, 1);
        chk("t2_done_early", bus.mem_done, 0);
        nxt();
        chk("t2_idle_gap", bus.ram_req, 0);
        chk("t2_stall_gap", bus.pipe_stall, 1);
        chk("t2_instr", bus.if_instr, 32'hC0DE_0104);
        nxt();
        chk("t2_data_req", bus.ram_req, 1);
        chk("t2_data_addr", bus.ram_addr, 32'h2000);
        chk("t2_data_we", bus.ram_we, 0);
        chk("t2_stall_data", bus.pipe_stall, 1);
        nxt();
        chk("t2_done", bus.mem_done, 1);
        chk("t2_rdata", bus.mem_rdata, 32'hC0DE_2000);
        chk("t2_stall_release", bus.pipe_stall, 0);
        bus.mem_rd = 0;
        nxt();
        chk("t2_back_idle", bus.ram_req, 0);
        chk("t2_done_clear", bus.mem_done, 0);

        // 3: fetch and store requested together; store wins
        bus.if_accept = 1; bus.if_addr = 32'h108; lat = 1;
        bus.mem_wr = 1; bus.mem_addr = 32'h3000; bus.mem_wdata = 32'hDEAD_BEEF;
        nxt();
        chk("t3_we", bus.ram_we, 1);
        chk("t3_addr", bus.ram_addr, 32'h3000);
        chk("t3_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        chk("t3_done", bus.mem_done, 1);
        chk("t3_rdata_store", bus.mem_rdata, 0);
        chk("t3_valid", bus.if_valid, 0);
        bus.if_accept = 0; bus.mem_wr = 0;
        nxt();
        chk("t3_if_waits", bus.ram_req, 0);
        nxt();
        chk("t3_fetch_addr", bus.ram_addr, 32'h108);
        chk("t3_fetch_we", bus.ram_we, 0);
        nxt();
        chk("t3_instr", bus.if_instr, 32'hC0DE_0108);

        // 4: flush one cycle after a fetch grant
        bus.if_accept = 1; bus.if_addr = 32'h10C; lat = 3;
        nxt();
        chk("t4_addr", bus.ram_addr, 32'h10C);
        bus.if_accept = 0; bus.if_flush = 1; bus.if_addr = 32'h200;
        nxt();
        bus.if_flush = 0;
        chk("t4_still_fetch", bus.ram_req, 1);
        nxt();
        chk("t4_ready_seen", bus.ram_ready, 1);
        nxt();
        chk("t4_dropped", bus.if_valid, 0);
        chk("t4_idle", bus.ram_req, 0);
        nxt();
        chk("t4_refetch_addr", bus.ram_addr, 32'h200);
        nxt(); nxt(); nxt();
        chk("t4_valid", bus.if_valid, 1);
        chk("t4_instr", bus.if_instr, 32'hC0DE_0200);

        // flush in IDLE clears the buffer and blocks the grant
        bus.if_accept = 1; bus.if_flush = 1;
        nxt();
        chk("t4_flush_nogrant", bus.ram_req, 0);
        chk("t4_flush_clear", bus.if_valid, 0);
        bus.if_accept = 0; bus.if_flush = 0; bus.if_addr = 32'h204;
        nxt();
        chk("t4_grant_after", bus.ram_addr, 32'h204);
        bus.if_req = 0;
        wait_idle(10);
        chk("t4_instr2", bus.if_instr, 32'hC0DE_0204);

        // 5a: ready in the would-be abort cycle completes normally
        lat = 16; bus.mem_rd = 1; bus.mem_addr = 32'h5000;
        reqs = 0;
        for (int i = 0; i < 15; i++) begin
            nxt();
            reqs += int'(bus.ram_req && !bus.mem_done);
        end
        chk("t5a_wait_cycles", reqs, 15);
        nxt();
        chk("t5a_done", bus.mem_done, 1);
        chk("t5a_rdata", bus.mem_rdata, 32'hC0DE_5000);
        bus.mem_rd = 0;
        nxt();
        chk("t5a_no_err", bus.bus_err, 0);

        // 5: latency 20 exceeds the watchdog
        lat = 20; bus.mem_rd = 1; bus.mem_addr = 32'h4000;
        reqs = 0;
        for (int i = 0; i < 15; i++) begin
            nxt();
            reqs += int'(bus.ram_req && !bus.mem_done);
        end
        chk("t5_wait_cycles", reqs, 15);
        nxt();
        chk("t5_abort_done", bus.mem_done, 1);
        chk("t5_abort_rdata", bus.mem_rdata, 0);
        chk("t5_abort_stall", bus.pipe_stall, 0);
        bus.mem_rd = 0;
        nxt();
        chk("t5_req_drop", bus.ram_req, 0);
        chk("t5_err", bus.bus_err, 1);
        stray = 1;
        nxt();
        chk("t5_stray_ignored", bus.mem_done, 0);
        stray = 0;
        nxt();
        chk("t5_stray_idle", bus.ram_req, 0);
        chk("t5_err_sticky", bus.bus_err, 1);
        chk("t5_buf_kept", bus.if_instr, 32'hC0DE_0204);

        // 6: asynchronous reset in the middle of a store
        lat = 5; bus.mem_wr = 1; bus.mem_addr = 32'h6000; bus.mem_wdata = 32'h1234_5678;
        nxt();
        chk("t6_store_req", bus.ram_req, 1);
        chk("t6_store_we", bus.ram_we, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_req", bus.ram_req, 0);
        chk("t6_rst_we", bus.ram_we, 0);
        chk("t6_rst_addr", bus.ram_addr, 0);
        chk("t6_rst_wdata", bus.ram_wdata, 0);
        chk("t6_rst_err", bus.bus_err, 0);
        chk("t6_rst_valid", bus.if_valid, 0);
        chk("t6_rst_done", bus.mem_done, 0);
        bus.mem_wr = 0; bus.mem_rd = 1; bus.mem_addr = 32'h7000; lat = 1;
        nxt();
        rst_n = 1;
        nxt();
        chk("t6_fresh_addr", bus.ram_addr, 32'h7000);
        chk("t6_fresh_we", bus.ram_we, 0);
        chk("t6_fresh_done", bus.mem_done, 1);
        chk("t6_fresh_rdata", bus.mem_rdata, 32'hC0DE_7000);
        bus.mem_rd = 0;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
